// File: rtl/lap_timer_multi.sv
// Multi-car BCD lap timer: one shared tick prescaler feeding NUM_CARS independent
// timing channels, each with current/last/best lap time, lap counter, timeout flag
// and an invalid-lap pulse. Buses are flat-packed with car 0 in the LSBs.
// Optional build macro: LAP_TIMER_MIN_LAP_EN rejects laps shorter than MIN_LAP_TIME.
module lap_timer_multi #(
  parameter int unsigned          NUM_CARS     = 2,
  parameter int unsigned          DIGITS       = 4,
  parameter int unsigned          CLK_HZ       = 65000000,
  parameter int unsigned          TICK_HZ      = 100,
  parameter logic [4*DIGITS-1:0]  MAX_LAP_TIME = 16'h5999,
  parameter logic [4*DIGITS-1:0]  MIN_LAP_TIME = 16'h0500
) (
  input  logic                         pclk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         stop,
  input  logic [NUM_CARS-1:0]          lap_finished,
  input  logic [NUM_CARS-1:0]          checkpoints_passed,
  output logic [NUM_CARS*4*DIGITS-1:0] current_lap_time,
  output logic [NUM_CARS*4*DIGITS-1:0] last_lap_time,
  output logic [NUM_CARS*4*DIGITS-1:0] best_lap_time,
  output logic [NUM_CARS*8-1:0]        lap_count,
  output logic [NUM_CARS-1:0]          max_time_exceeded,
  output logic [NUM_CARS-1:0]          invalid_lap
);

  localparam int unsigned Tw      = 4 * DIGITS;
  localparam int unsigned Div     = CLK_HZ / TICK_HZ;
  localparam int unsigned CntW    = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] DivLast = CntW'(Div - 1);

`ifdef LAP_TIMER_MIN_LAP_EN
  localparam bit MinLapEn = 1'b1;
`else
  localparam bit MinLapEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StRunning, StTimeout} state_e;

  // BCD +1 with the full digit carry chain resolved combinationally.
  function automatic logic [Tw-1:0] bcd_inc(input logic [Tw-1:0] v);
    logic [Tw-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (carry) begin
        if (v[4*d +: 4] == 4'd9) begin
          r[4*d +: 4] = 4'd0;
        end else begin
          r[4*d +: 4] = v[4*d +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic [CntW-1:0] presc_q, presc_d;
  logic            tick;

  state_e          state_q [NUM_CARS];
  state_e          state_d [NUM_CARS];
  logic [Tw-1:0]   cur_q   [NUM_CARS];
  logic [Tw-1:0]   cur_d   [NUM_CARS];
  logic [Tw-1:0]   last_q  [NUM_CARS];
  logic [Tw-1:0]   last_d  [NUM_CARS];
  logic [Tw-1:0]   best_q  [NUM_CARS];
  logic [Tw-1:0]   best_d  [NUM_CARS];
  logic [7:0]      cnt_q   [NUM_CARS];
  logic [7:0]      cnt_d   [NUM_CARS];
  logic [Tw-1:0]   cur_inc [NUM_CARS];
  logic [NUM_CARS-1:0] bval_q, bval_d;
  logic [NUM_CARS-1:0] tmo_q, tmo_d;
  logic [NUM_CARS-1:0] inv_q, inv_d;
  logic [NUM_CARS-1:0] lap_ev, lap_ok;

  // Shared prescaler: clears while idle, freezes on stop, ticks on the last count.
  always_comb begin
    presc_d = presc_q;
    tick    = 1'b0;
    if (!start) begin
      presc_d = '0;
    end else if (!stop) begin
      if (presc_q == DivLast) begin
        tick    = 1'b1;
        presc_d = '0;
      end else begin
        presc_d = presc_q + CntW'(1);
      end
    end
  end

  // Per-car lap qualification and incremented time.
  always_comb begin
    lap_ev = '0;
    lap_ok = '0;
    for (int c = 0; c < int'(NUM_CARS); c++) begin
      cur_inc[c] = bcd_inc(cur_q[c]);
      lap_ev[c]  = lap_finished[c] && !stop;
      lap_ok[c]  = checkpoints_passed[c] && (!MinLapEn || (cur_q[c] >= MIN_LAP_TIME));
    end
  end

  // Per-car FSM and lap bookkeeping.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    last_d  = last_q;
    best_d  = best_q;
    cnt_d   = cnt_q;
    bval_d  = bval_q;
    tmo_d   = tmo_q;
    inv_d   = '0;
    for (int c = 0; c < int'(NUM_CARS); c++) begin
      if (!start) begin
        state_d[c] = StIdle;
        cur_d[c]   = '0;
        tmo_d[c]   = 1'b0;
      end else begin
        case (state_q[c])
          StIdle: begin
            state_d[c] = StRunning;
          end
          StRunning: begin
            if (lap_ev[c] && lap_ok[c]) begin
              // Valid lap wins over a same-cycle tick; the tick is dropped.
              last_d[c] = cur_q[c];
              cur_d[c]  = '0;
              if (cnt_q[c] != 8'hFF) cnt_d[c] = cnt_q[c] + 8'd1;
              if (!bval_q[c] || (cur_q[c] < best_q[c])) best_d[c] = cur_q[c];
              bval_d[c] = 1'b1;
            end else begin
              if (lap_ev[c]) inv_d[c] = 1'b1;
              if (tick) begin
                cur_d[c] = cur_inc[c];
                if (cur_inc[c] == MAX_LAP_TIME) begin
                  tmo_d[c]   = 1'b1;
                  state_d[c] = StTimeout;
                end
              end
            end
          end
          StTimeout: begin
            state_d[c] = StTimeout;
          end
          default: begin
            state_d[c] = StIdle;
          end
        endcase
      end
    end
  end

  // State registers.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      bval_q  <= '0;
      tmo_q   <= '0;
      inv_q   <= '0;
      for (int c = 0; c < int'(NUM_CARS); c++) begin
        state_q[c] <= StIdle;
        cur_q[c]   <= '0;
        last_q[c]  <= '0;
        best_q[c]  <= '0;
        cnt_q[c]   <= '0;
      end
    end else begin
      presc_q <= presc_d;
      bval_q  <= bval_d;
      tmo_q   <= tmo_d;
      inv_q   <= inv_d;
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      best_q  <= best_d;
      cnt_q   <= cnt_d;
    end
  end

  // Flat-pack per-car registers onto the output buses.
  always_comb begin
    current_lap_time  = '0;
    last_lap_time     = '0;
    best_lap_time     = '0;
    lap_count         = '0;
    for (int c = 0; c < int'(NUM_CARS); c++) begin
      current_lap_time[c*Tw +: Tw] = cur_q[c];
      last_lap_time[c*Tw +: Tw]    = last_q[c];
      best_lap_time[c*Tw +: Tw]    = best_q[c];
      lap_count[c*8 +: 8]          = cnt_q[c];
    end
    max_time_exceeded = tmo_q;
    invalid_lap       = inv_q;
  end

endmodule

// File: tb/tb_lap_timer_multi.sv
// Self-checking bench for lap_timer_multi (2 cars, 4 digits, DIV=10).
// Main instance uses the default timeout; a second instance uses a 0010 timeout.
module tb_lap_timer_multi;

  logic        pclk;
  logic        rst;
  logic        start;
  logic        stop;
  logic [1:0]  lap;
  logic [1:0]  cp;

  logic [31:0] cur, last, best;
  logic [15:0] cnt;
  logic [1:0]  tmo, inv;
  logic [31:0] t_cur, t_last, t_best;
  logic [15:0] t_cnt;
  logic [1:0]  t_tmo, t_inv;

  int checks = 0;
  int errors = 0;

  lap_timer_multi #(
    .NUM_CARS(2), .DIGITS(4), .CLK_HZ(10), .TICK_HZ(1),
    .MAX_LAP_TIME(16'h5999), .MIN_LAP_TIME(16'h0005)
  ) dut (
    .pclk(pclk), .rst(rst), .start(start), .stop(stop),
    .lap_finished(lap), .checkpoints_passed(cp),
    .current_lap_time(cur), .last_lap_time(last), .best_lap_time(best),
    .lap_count(cnt), .max_time_exceeded(tmo), .invalid_lap(inv)
  );

  lap_timer_multi #(
    .NUM_CARS(2), .DIGITS(4), .CLK_HZ(10), .TICK_HZ(1),
    .MAX_LAP_TIME(16'h0010), .MIN_LAP_TIME(16'h0005)
  ) dut_t (
    .pclk(pclk), .rst(rst), .start(start), .stop(stop),
    .lap_finished(lap), .checkpoints_passed(cp),
    .current_lap_time(t_cur), .last_lap_time(t_last), .best_lap_time(t_best),
    .lap_count(t_cnt), .max_time_exceeded(t_tmo), .invalid_lap(t_inv)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    int unsigned adv;
    logic [1:0]  lap;
    logic [1:0]  cp;
    logic [15:0] cur0, cur1, last0, last1, best0, best1;
    logic [7:0]  cnt0, cnt1;
    logic [1:0]  inv;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  initial begin
    // Edge counts are relative to the edge after which start rises.
    tbl[0] = '{989,  2'b00, 2'b00, 16'h0099, 16'h0099, 16'h0000, 16'h0000,
               16'h0000, 16'h0000, 8'd0, 8'd0, 2'b00};
    tbl[1] = '{9,    2'b00, 2'b00, 16'h0100, 16'h0100, 16'h0000, 16'h0000,
               16'h0000, 16'h0000, 8'd0, 8'd0, 2'b00};
    tbl[2] = '{239,  2'b10, 2'b00, 16'h0124, 16'h0124, 16'h0000, 16'h0000,
               16'h0000, 16'h0000, 8'd0, 8'd0, 2'b10};
    tbl[3] = '{0,    2'b00, 2'b00, 16'h0124, 16'h0124, 16'h0000, 16'h0000,
               16'h0000, 16'h0000, 8'd0, 8'd0, 2'b00};
    tbl[4] = '{1768, 2'b01, 2'b01, 16'h0000, 16'h0301, 16'h0300, 16'h0000,
               16'h0300, 16'h0000, 8'd1, 8'd0, 2'b00};
    tbl[5] = '{2509, 2'b11, 2'b11, 16'h0000, 16'h0000, 16'h0250, 16'h0551,
               16'h0250, 16'h0551, 8'd2, 8'd1, 2'b00};
    tbl[6] = '{4000, 2'b01, 2'b01, 16'h0000, 16'h0400, 16'h0400, 16'h0551,
               16'h0250, 16'h0551, 8'd3, 8'd1, 2'b00};
    tbl[7] = '{5988, 2'b00, 2'b00, 16'h0599, 16'h0999, 16'h0400, 16'h0551,
               16'h0250, 16'h0551, 8'd3, 8'd1, 2'b00};
    tbl[8] = '{9,    2'b00, 2'b00, 16'h0600, 16'h1000, 16'h0400, 16'h0551,
               16'h0250, 16'h0551, 8'd3, 8'd1, 2'b00};

    rst = 1'b0; start = 1'b0; stop = 1'b0; lap = 2'b00; cp = 2'b00;
    repeat (3) step();
    chk("reset cur", cur, 32'h0);
    chk("reset last", last, 32'h0);
    chk("reset best", best, 32'h0);
    chk("reset cnt", 32'(cnt), 32'h0);
    chk("reset tmo/inv", 32'({tmo, inv}), 32'h0);
    rst = 1'b1;
    repeat (2) step();
    chk("idle cur", cur, 32'h0);
    start = 1'b1;

    for (int i = 0; i < 9; i++) begin
      repeat (tbl[i].adv) step();
      lap = tbl[i].lap;
      cp  = tbl[i].cp;
      step();
      lap = 2'b00;
      cp  = 2'b00;
      chk($sformatf("v%0d cur0", i),  32'(cur[15:0]),   32'(tbl[i].cur0));
      chk($sformatf("v%0d cur1", i),  32'(cur[31:16]),  32'(tbl[i].cur1));
      chk($sformatf("v%0d last0", i), 32'(last[15:0]),  32'(tbl[i].last0));
      chk($sformatf("v%0d last1", i), 32'(last[31:16]), 32'(tbl[i].last1));
      chk($sformatf("v%0d best0", i), 32'(best[15:0]),  32'(tbl[i].best0));
      chk($sformatf("v%0d best1", i), 32'(best[31:16]), 32'(tbl[i].best1));
      chk($sformatf("v%0d cnt0", i),  32'(cnt[7:0]),    32'(tbl[i].cnt0));
      chk($sformatf("v%0d cnt1", i),  32'(cnt[15:8]),   32'(tbl[i].cnt1));
      chk($sformatf("v%0d inv", i),   32'(inv),         32'(tbl[i].inv));
      chk($sformatf("v%0d tmo", i),   32'(tmo),         32'h0);
    end

    // Stop: laps ignored without an invalid pulse, timing frozen, then resumes.
    stop = 1'b1;
    lap  = 2'b11;
    cp   = 2'b01;
    step();
    lap = 2'b00;
    cp  = 2'b00;
    chk("stop inv", 32'(inv), 32'h0);
    chk("stop cnt0", 32'(cnt[7:0]), 32'd3);
    repeat (49) step();
    chk("stop cur", cur, 32'h1000_0600);
    chk("stop last0", 32'(last[15:0]), 32'h0400);
    stop = 1'b0;
    repeat (9) step();
    chk("resume pre", cur, 32'h1000_0600);
    step();
    chk("resume tick", cur, 32'h1001_0601);

    // Asynchronous reset mid-run.
    rst   = 1'b0;
    start = 1'b0;
    #1;
    chk("async cur", cur, 32'h0);
    chk("async last", last, 32'h0);
    chk("async best", best, 32'h0);
    chk("async cnt", 32'(cnt), 32'h0);
    chk("async t_cur", t_cur, 32'h0);
    repeat (2) step();
    rst = 1'b1;
    step();
    start = 1'b1;

    // Short lap on car1 at 0003.
    repeat (30) step();
    lap = 2'b10;
    cp  = 2'b10;
    step();
    lap = 2'b00;
    cp  = 2'b00;
`ifdef LAP_TIMER_MIN_LAP_EN
    chk("minlap inv", 32'(t_inv), 32'b10);
    chk("minlap cnt1", 32'(t_cnt[15:8]), 32'd0);
    chk("minlap cur1", 32'(t_cur[31:16]), 32'h0003);
`else
    chk("minlap inv", 32'(t_inv), 32'b00);
    chk("minlap cnt1", 32'(t_cnt[15:8]), 32'd1);
    chk("minlap last1", 32'(t_last[31:16]), 32'h0003);
`endif

    // Valid lap on car0 at 0005 to seed best before timeout.
    repeat (23) step();
    lap = 2'b01;
    cp  = 2'b01;
    step();
    lap = 2'b00;
    cp  = 2'b00;
    chk("t lap last0", 32'(t_last[15:0]), 32'h0005);
    chk("t lap best0", 32'(t_best[15:0]), 32'h0005);
    chk("t lap cnt0", 32'(t_cnt[7:0]), 32'd1);
    chk("t lap cur0", 32'(t_cur[15:0]), 32'h0000);

    repeat (94) step();
    chk("t pre cur0", 32'(t_cur[15:0]), 32'h0009);
    chk("t pre tmo0", 32'(t_tmo[0]), 32'h0);
    step();
    chk("t hit cur0", 32'(t_cur[15:0]), 32'h0010);
    chk("t hit tmo0", 32'(t_tmo[0]), 32'h1);
    repeat (10) step();
    chk("t hold cur0", 32'(t_cur[15:0]), 32'h0010);
    chk("t hold tmo0", 32'(t_tmo[0]), 32'h1);
    lap = 2'b01;
    cp  = 2'b01;
    step();
    lap = 2'b00;
    cp  = 2'b00;
    chk("t drop cnt0", 32'(t_cnt[7:0]), 32'd1);
    chk("t drop last0", 32'(t_last[15:0]), 32'h0005);
    chk("t drop cur0", 32'(t_cur[15:0]), 32'h0010);
    start = 1'b0;
    step();
    chk("t idle tmo0", 32'(t_tmo[0]), 32'h0);
    chk("t idle cur0", 32'(t_cur[15:0]), 32'h0000);
    chk("t idle best0", 32'(t_best[15:0]), 32'h0005);
    chk("t idle cnt0", 32'(t_cnt[7:0]), 32'd1);
    chk("idle main cur", cur, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
